muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative HI/LO multiply/divide unit (shift-add / restoring)
// Rev 1.0     : initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     mag_b_q, mag_b_d;
  logic                 neg_a_q, neg_a_d;
  logic                 neg_b_q, neg_b_d;
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 in_neg_a, in_neg_b;
  logic [WIDTH-1:0]     in_mag_a, in_mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_rem;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // op[0]=0 selects the signed variants, so magnitudes are taken only then
  assign in_neg_a = ~op[0] & srcA[WIDTH-1];
  assign in_neg_b = ~op[0] & srcB[WIDTH-1];
  assign in_mag_a = in_neg_a ? -srcA : srcA;
  assign in_mag_b = in_neg_b ? -srcB : srcB;

  assign mul_sum      = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, mag_b_q} : '0);
  assign div_rem      = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign div_ge       = (div_rem >= {1'b0, mag_b_q});
  assign div_rem_next = div_ge ? (div_rem[WIDTH-1:0] - mag_b_q) : div_rem[WIDTH-1:0];

  assign prod_fix = (neg_a_q ^ neg_b_q) ? -work_q : work_q;
  assign quo_fix  = (neg_a_q ^ neg_b_q) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
  assign rem_fix  = neg_a_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    mag_b_d = mag_b_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    work_d  = work_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!op[2]) begin
            op_d    = op[1:0];
            a_d     = srcA;
            mag_b_d = in_mag_b;
            neg_a_d = in_neg_a;
            neg_b_d = in_neg_b;
            work_d  = {{WIDTH{1'b0}}, in_mag_a};
            cnt_d   = '0;
            state_d = S_RUN;
          end else if (op[1:0] == 2'b00) begin
            hi_d = srcA;
          end else if (op[1:0] == 2'b01) begin
            lo_d = srcA;
          end
        end
      end
      S_RUN: begin
        // work holds {partial product, multiplier} or {remainder, dividend/quotient}
        if (op_q[1]) begin
          work_d = {div_rem_next, work_q[WIDTH-2:0], div_ge};
        end else begin
          work_d = {mul_sum, work_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (!op_q[1]) begin
          {hi_d, lo_d} = prod_fix;
        end else if (mag_b_q == '0) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      mag_b_q <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      work_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      mag_b_q <= mag_b_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      work_q  <= work_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit : directed + randomized checks of muldiv_unit against a model
// Rev 1.0        : initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] srcA, srcB;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srcA  (srcA),
    .srcB  (srcB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi,lo} from plain integer arithmetic
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub;
    int          q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'h0) return {a, 32'hffffffff};
        if (a == 32'h80000000 && b == 32'hffffffff) return {32'h0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hffffffff};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Cycle model: m_rem counts edges remaining until IDLE after an accepted op
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int           m_rem = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi  = '0;
      m_lo  = '0;
      m_rem = 0;
    end else if (m_rem == 0) begin
      if (start) begin
        case (op)
          3'd0, 3'd1, 3'd2, 3'd3: begin
            {p_hi, p_lo} = ref_result(op, srcA, srcB);
            m_rem = W + 2;
          end
          3'd4: m_hi = srcA;
          3'd5: m_lo = srcA;
          default: ;
        endcase
      end
    end else begin
      m_rem--;
      if (m_rem == 1) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("busy", 64'(busy), 64'(m_rem != 0));
    check("done", 64'(done), 64'(m_rem == 1));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
  end

  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string name, input logic [63:0] exp);
    int k;
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(negedge clk);
    start = 1'b0; srcA = $urandom; srcB = $urandom;
    wait_done(0, k);
    check({name, "_latency"}, 64'(k), 64'd33);
    check({name, "_result"}, {hi, lo}, exp);
    @(negedge clk);
    check({name, "_done_single"}, 64'(done), 64'd0);
  endtask

  initial begin
    int k;
    bit saw;
    reset = 1'b1; start = 1'b0; op = 3'd0; srcA = '0; srcB = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {30'h0, busy, done, hi}, 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    reset = 1'b0;

    do_op(3'd1, 32'hffffffff, 32'hffffffff, "multu_max", 64'hfffffffe_00000001);
    do_op(3'd0, 32'hfffffffd, 32'h00000005, "mult_neg", 64'hffffffff_fffffff1);
    do_op(3'd2, 32'hfffffff9, 32'h00000002, "div_neg", 64'hffffffff_fffffffd);
    do_op(3'd3, 32'h0000000a, 32'h00000000, "divu_zero", 64'h0000000a_ffffffff);
    do_op(3'd2, 32'h80000000, 32'hffffffff, "div_ovf", 64'h00000000_80000000);

    @(negedge clk);
    start = 1'b1; op = 3'd4; srcA = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    check("mthi_hi", 64'(hi), 64'h12345678);
    check("mthi_busy_done", {busy, done}, 64'd0);
    start = 1'b1; op = 3'd5; srcA = 32'h9abcdef0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo", {hi, lo}, 64'h12345678_9abcdef0);
    check("mtlo_busy_done", {busy, done}, 64'd0);
    start = 1'b1; op = 3'd6; srcA = 32'hdeadbeef;
    @(negedge clk);
    start = 1'b1; op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    check("reserved", {hi, lo}, 64'h12345678_9abcdef0);
    check("reserved_busy", 64'(busy), 64'd0);

    // second request while the first is running must be dropped
    start = 1'b1; op = 3'd1; srcA = 32'd3; srcB = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd3; srcA = 32'd100; srcB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, k);
    check("inflight_latency", 64'(k), 64'd33);
    check("inflight_result", {hi, lo}, 64'h00000000_0000000c);
    @(negedge clk);
    @(negedge clk);
    check("inflight_no_second", {busy, done}, 64'd0);

    // reset mid-run aborts the operation
    start = 1'b1; op = 3'd0; srcA = 32'h00001234; srcB = 32'h00005678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_state", {30'h0, busy, done, hi}, 64'h0);
    check("abort_lo", 64'(lo), 64'h0);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    check("abort_no_done", 64'(saw), 64'd0);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       srcA = 32'h80000000;
        1:       srcA = 32'h0;
        2:       srcA = 32'hffffffff;
        default: srcA = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       srcB = 32'h0;
        1:       srcB = 32'hffffffff;
        2:       srcB = 32'h1;
        default: srcB = $urandom;
      endcase
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("final_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
